processor_regfile: RTL and testbench
====================================

Name: processor_regfile

Overview:
- Architectural register file: the receiving end of the stage-3 register write interface (reg_write_enable / reg_write_addr / reg_write_data).
- Holds 8 general registers.
- Serves two synchronous read ports to the operand-fetch stage, with write-to-read bypass.
- Provides a debug dump port that streams all registers over a valid/ready handshake.

Parameters:
- WORD_SIZE, 18, register width in bits
- REG_COUNT, 8, number of registers; address width fixed at 3 bits

Ports:
- clock  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clock)
- reg_write_enable  input  1  write strobe from stage 3
- reg_write_addr  input  3  register written
- reg_write_data  input  WORD_SIZE  data written
- read_addr0  input  3  read port 0 address
- read_addr1  input  3  read port 1 address
- read_data0  output  WORD_SIZE  read port 0 data, registered
- read_data1  output  WORD_SIZE  read port 1 data, registered
- dump_start  input  1  one-cycle request to stream all registers
- dump_valid  output  1  dump element present
- dump_ready  input  1  consumer accepts element
- dump_addr  output  3  index of presented register
- dump_data  output  WORD_SIZE  presented register value
- dump_done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (reset==0 at posedge):
  - all registers = 0
  - read_data0/1 = 0
  - dump_valid = 0, dump_addr = 0, dump_data = 0, dump_done = 0
  - dump FSM -> IDLE
  - Reset mid-dump aborts the dump with no dump_done.
- Write: when reg_write_enable==1, regs[reg_write_addr] <= reg_write_data at posedge.
- Read: 1-cycle latency; read_dataN <= regs[read_addrN].
- Bypass: if reg_write_enable and reg_write_addr==read_addrN in the same cycle, read_dataN <= reg_write_data (new value, not old). Both ports bypass independently; same address on both ports is legal.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_valid=0. If dump_start==1, load index 0 and go to SEND.
  - SEND: dump_valid=1.
    - On dump_valid&&dump_ready: if index==REG_COUNT-1, go to DONE; else increment index and load the next element.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
- Element load: dump_addr <= index; dump_data <= regs[index], with write bypass if a write to index occurs in the same cycle.
- Handshake stability: while dump_valid && !dump_ready, dump_addr and dump_data hold stable even if the presented register is written. The snapshot is per element.
- dump_ready while dump_valid==0 has no effect.
- dump_start while in SEND or DONE is ignored.
- Back-to-back: with dump_ready held at 1, one element is transferred per cycle. The full dump takes 8 cycles in SEND, then 1 in DONE.
- Register writes and reads are never stalled by the dump.

Optional Feature:
- Macro: PROCESSOR_REGFILE_ZERO_REG_EN
- Defined:
  - register 0 is hardwired to 0; writes to addr 0 are discarded
  - reads, bypass and dump of addr 0 always return 0 (a write to 0 is not bypassed)
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package processor_pkg holds:
  - REG_ADDR_WIDTH = 3
  - REG_COUNT = 8
  - typedef enum regfile_dump_state_t {DUMP_IDLE, DUMP_SEND, DUMP_DONE}
- Sub-module processor_regfile_dump: owns the FSM, index counter and handshake. It receives a read address and data from the register array and returns dump outputs.
- The array, read ports and bypass stay in the top module.

Test Plan:
- Reset, then write addr 3 = 18'h2A5A5; next cycle read_addr0=3 -> read_data0=18'h2A5A5 one cycle later. Before any write, reads of all addresses return 0.
- Bypass: same cycle write addr 5 = 18'h00123, read_addr0=5, read_addr1=5 -> both read_data = 18'h00123 next cycle, not the old value.
- Dump with dump_ready=1, regs i = i*18'h111 -> 8 consecutive beats with dump_addr 0..7 and matching data, then dump_done high exactly one cycle, then dump_valid=0.
- Stall: dump_ready=0 for 4 cycles on element 2 while writing addr 2 = 18'h3FFFF -> dump_data holds the old value; writes to addr 4 during the stall appear when element 4 loads.
- Reset asserted (reset=0) during element 5 -> next cycle dump_valid=0, no dump_done, all regs=0. dump_start issued during SEND is ignored, with no restart of the sequence.
- With PROCESSOR_REGFILE_ZERO_REG_EN: write addr 0 = 18'h1 -> read_data0=0 (including the same-cycle bypass case) and dump beat 0 data=0. Without the macro: read returns 18'h1.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor register file and its dump streamer.
package processor_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 3;
   localparam int unsigned REG_COUNT      = 8;

   typedef enum logic [1:0] {
      DUMP_IDLE,
      DUMP_SEND,
      DUMP_DONE
   } regfile_dump_state_t;

endpackage

// File: rtl/processor_regfile_dump.sv
// Debug dump streamer: walks every register over a valid/ready handshake, then pulses done.
module processor_regfile_dump
   import processor_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 18
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_ready,
   output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [WORD_SIZE-1:0]      i_rd_data,
   output logic                      o_valid,
   output logic [REG_ADDR_WIDTH-1:0] o_addr,
   output logic [WORD_SIZE-1:0]      o_data,
   output logic                      o_done
);

   localparam logic [REG_ADDR_WIDTH-1:0] LastIdx = REG_ADDR_WIDTH'(REG_COUNT - 1);

   regfile_dump_state_t       r_state;
   logic                      r_valid;
   logic                      r_done;
   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic [WORD_SIZE-1:0]      r_data;
   logic [REG_ADDR_WIDTH-1:0] w_rd_addr;
   logic                      w_accept;

   assign w_accept  = r_valid && i_ready;
   // Element 0 is fetched from IDLE; each later element on the cycle the previous is accepted.
   assign w_rd_addr = (r_state == DUMP_IDLE) ? '0 : r_addr + REG_ADDR_WIDTH'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= DUMP_IDLE;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            DUMP_IDLE: begin
               if (i_start) begin
                  r_state <= DUMP_SEND;
                  r_valid <= 1'b1;
                  r_addr  <= w_rd_addr;
                  r_data  <= i_rd_data;
               end
            end
            DUMP_SEND: begin
               if (w_accept) begin
                  if (r_addr == LastIdx) begin
                     r_state <= DUMP_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr <= w_rd_addr;
                     r_data <= i_rd_data;
                  end
               end
            end
            DUMP_DONE: r_state <= DUMP_IDLE;
            default:   r_state <= DUMP_IDLE;
         endcase
      end
   end

   assign o_rd_addr = w_rd_addr;
   assign o_valid   = r_valid;
   assign o_addr    = r_addr;
   assign o_data    = r_data;
   assign o_done    = r_done;

endmodule

// File: rtl/processor_regfile.sv
// Architectural register file: 8 registers, two bypassed registered read ports, debug dump port.
// Optional macro PROCESSOR_REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module processor_regfile
   import processor_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 18
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      reg_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr,
   input  logic [WORD_SIZE-1:0]      reg_write_data,
   input  logic [REG_ADDR_WIDTH-1:0] read_addr0,
   input  logic [REG_ADDR_WIDTH-1:0] read_addr1,
   output logic [WORD_SIZE-1:0]      read_data0,
   output logic [WORD_SIZE-1:0]      read_data1,
   input  logic                      dump_start,
   output logic                      dump_valid,
   input  logic                      dump_ready,
   output logic [REG_ADDR_WIDTH-1:0] dump_addr,
   output logic [WORD_SIZE-1:0]      dump_data,
   output logic                      dump_done
);

   logic [WORD_SIZE-1:0]      r_regs [REG_COUNT];
   logic [WORD_SIZE-1:0]      r_read_data0;
   logic [WORD_SIZE-1:0]      r_read_data1;
   logic                      w_wr_en;
   logic [WORD_SIZE-1:0]      w_rd0;
   logic [WORD_SIZE-1:0]      w_rd1;
   logic [REG_ADDR_WIDTH-1:0] w_dump_rd_addr;
   logic [WORD_SIZE-1:0]      w_dump_rd_data;

`ifdef PROCESSOR_REGFILE_ZERO_REG_EN
   // Dropping the write here keeps register 0 at zero and suppresses its bypass everywhere.
   assign w_wr_en = reg_write_enable && (reg_write_addr != '0);
`else
   assign w_wr_en = reg_write_enable;
`endif

   assign w_rd0 = (w_wr_en && (reg_write_addr == read_addr0)) ? reg_write_data
                                                              : r_regs[read_addr0];
   assign w_rd1 = (w_wr_en && (reg_write_addr == read_addr1)) ? reg_write_data
                                                              : r_regs[read_addr1];
   assign w_dump_rd_data = (w_wr_en && (reg_write_addr == w_dump_rd_addr)) ? reg_write_data
                                                                          : r_regs[w_dump_rd_addr];

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
         r_read_data0 <= '0;
         r_read_data1 <= '0;
      end else begin
         if (w_wr_en) begin
            r_regs[reg_write_addr] <= reg_write_data;
         end
         r_read_data0 <= w_rd0;
         r_read_data1 <= w_rd1;
      end
   end

   assign read_data0 = r_read_data0;
   assign read_data1 = r_read_data1;

   processor_regfile_dump #(
      .WORD_SIZE (WORD_SIZE)
   ) u_dump (
      .i_clk     (clock),
      .i_rst_n   (reset),
      .i_start   (dump_start),
      .i_ready   (dump_ready),
      .o_rd_addr (w_dump_rd_addr),
      .i_rd_data (w_dump_rd_data),
      .o_valid   (dump_valid),
      .o_addr    (dump_addr),
      .o_data    (dump_data),
      .o_done    (dump_done)
   );

endmodule

// File: tb/tb_processor_regfile.sv
// Self-checking bench for processor_regfile: random read/write traffic against an array model,
// plus directed bypass, dump, stall, mid-dump reset and register-0 scenarios.
module tb_processor_regfile;
   import processor_pkg::*;

   localparam int unsigned W = 18;
`ifdef PROCESSOR_REGFILE_ZERO_REG_EN
   localparam bit ZeroEn = 1'b1;
`else
   localparam bit ZeroEn = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          reg_write_enable;
   logic [2:0]    reg_write_addr;
   logic [W-1:0]  reg_write_data;
   logic [2:0]    read_addr0;
   logic [2:0]    read_addr1;
   logic [W-1:0]  read_data0;
   logic [W-1:0]  read_data1;
   logic          dump_start;
   logic          dump_valid;
   logic          dump_ready;
   logic [2:0]    dump_addr;
   logic [W-1:0]  dump_data;
   logic          dump_done;

   always #5 clock = ~clock;

   processor_regfile #(
      .WORD_SIZE (W)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .reg_write_enable (reg_write_enable),
      .reg_write_addr   (reg_write_addr),
      .reg_write_data   (reg_write_data),
      .read_addr0       (read_addr0),
      .read_addr1       (read_addr1),
      .read_data0       (read_data0),
      .read_data1       (read_data1),
      .dump_start       (dump_start),
      .dump_valid       (dump_valid),
      .dump_ready       (dump_ready),
      .dump_addr        (dump_addr),
      .dump_data        (dump_data),
      .dump_done        (dump_done)
   );

   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;
   logic [W-1:0] mregs [8];
   logic [W-1:0] exp_rd0;
   logic [W-1:0] exp_rd1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; the model applies the inputs present at that edge.
   task automatic step();
      if (!reset) begin
         foreach (mregs[i]) mregs[i] = '0;
         exp_rd0 = '0;
         exp_rd1 = '0;
      end else begin
         exp_rd0 = mregs[read_addr0];
         exp_rd1 = mregs[read_addr1];
         if (reg_write_enable && !(ZeroEn && reg_write_addr == 3'd0)) begin
            mregs[reg_write_addr] = reg_write_data;
            if (read_addr0 == reg_write_addr) exp_rd0 = reg_write_data;
            if (read_addr1 == reg_write_addr) exp_rd1 = reg_write_data;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      reg_write_enable = 1'b0;
      reg_write_addr = '0;
      reg_write_data = '0;
      read_addr0 = '0;
      read_addr1 = '0;
      dump_start = 1'b0;
      dump_ready = 1'b0;
      foreach (mregs[i]) mregs[i] = 'x;
      step();
      step();

      check_eq("rst_rd0", read_data0, 0);
      check_eq("rst_rd1", read_data1, 0);
      check_eq("rst_dvalid", dump_valid, 0);
      check_eq("rst_daddr", dump_addr, 0);
      check_eq("rst_ddata", dump_data, 0);
      check_eq("rst_ddone", dump_done, 0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         read_addr0 = 3'(i);
         read_addr1 = 3'(7 - i);
         step();
         check_eq("init_rd0", read_data0, 0);
         check_eq("init_rd1", read_data1, 0);
      end

      // Write then read on the following cycle.
      reg_write_enable = 1'b1; reg_write_addr = 3'd3; reg_write_data = 18'h2A5A5;
      step();
      reg_write_enable = 1'b0; read_addr0 = 3'd3;
      step();
      check_eq("wr_rd_a3", read_data0, 18'h2A5A5);

      // Bypass must deliver the new value, not the one already stored.
      reg_write_enable = 1'b1; reg_write_addr = 3'd5; reg_write_data = 18'h30000;
      step();
      reg_write_data = 18'h00123; read_addr0 = 3'd5; read_addr1 = 3'd5;
      step();
      check_eq("byp_rd0", read_data0, 18'h00123);
      check_eq("byp_rd1", read_data1, 18'h00123);
      reg_write_enable = 1'b0;

      for (int n = 0; n < 300; n++) begin
         reg_write_enable = 1'($urandom_range(0, 1));
         reg_write_addr   = 3'($urandom_range(0, 7));
         reg_write_data   = 18'($urandom);
         read_addr0 = ($urandom_range(0, 3) == 0) ? reg_write_addr : 3'($urandom_range(0, 7));
         read_addr1 = ($urandom_range(0, 3) == 0) ? reg_write_addr : 3'($urandom_range(0, 7));
         step();
         check_eq("rnd_rd0", read_data0, 32'(exp_rd0));
         check_eq("rnd_rd1", read_data1, 32'(exp_rd1));
      end

      // Back-to-back dump of regs i = i*0x111, with a stray start mid-sequence.
      for (int i = 0; i < 8; i++) begin
         reg_write_enable = 1'b1; reg_write_addr = 3'(i); reg_write_data = 18'(i * 'h111);
         step();
      end
      reg_write_enable = 1'b0;
      dump_ready = 1'b1; dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         check_eq("b2b_valid", dump_valid, 1);
         check_eq("b2b_addr", dump_addr, 32'(b));
         check_eq("b2b_data", dump_data, 32'(18'(b * 'h111)));
         check_eq("b2b_done", dump_done, 0);
         dump_start = (b == 3);
         step();
      end
      dump_start = 1'b0;
      check_eq("b2b_end_valid", dump_valid, 0);
      check_eq("b2b_end_done", dump_done, 1);
      step();
      check_eq("b2b_post_done", dump_done, 0);
      check_eq("b2b_post_valid", dump_valid, 0);

      // Stall on element 2 while writing it and element 4.
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         check_eq("stl_pre_addr", dump_addr, 32'(b));
         step();
      end
      check_eq("stl_e2_addr", dump_addr, 2);
      check_eq("stl_e2_data", dump_data, 18'h00222);
      dump_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         reg_write_enable = 1'b1;
         reg_write_addr   = (s == 0) ? 3'd2 : 3'd4;
         reg_write_data   = (s == 0) ? 18'h3FFFF : 18'(18'h10000 + s);
         step();
         check_eq("stl_hold_valid", dump_valid, 1);
         check_eq("stl_hold_addr", dump_addr, 2);
         check_eq("stl_hold_data", dump_data, 18'h00222);
      end
      reg_write_enable = 1'b0; dump_ready = 1'b1;
      for (int b = 3; b < 8; b++) begin
         step();
         check_eq("stl_post_addr", dump_addr, 32'(b));
         check_eq("stl_post_data", dump_data, (b == 4) ? 18'h10003 : 32'(18'(b * 'h111)));
      end
      read_addr0 = 3'd2;
      step();
      check_eq("stl_done", dump_done, 1);
      check_eq("stl_rd_a2", read_data0, 18'h3FFFF);

      // Register 0 write, including same-cycle bypass and dump of element 0.
      reg_write_enable = 1'b1; reg_write_addr = 3'd0; reg_write_data = 18'h00001;
      read_addr0 = 3'd0; read_addr1 = 3'd0;
      step();
      check_eq("z_byp_rd0", read_data0, ZeroEn ? 0 : 1);
      check_eq("z_byp_rd1", read_data1, ZeroEn ? 0 : 1);
      reg_write_enable = 1'b0;
      step();
      check_eq("z_rd0", read_data0, ZeroEn ? 0 : 1);
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      check_eq("z_dump_addr", dump_addr, 0);
      check_eq("z_dump_data", dump_data, ZeroEn ? 0 : 1);

      // Reset during element 5 aborts the dump without a done pulse.
      for (int b = 0; b < 5; b++) step();
      check_eq("rstd_e5_addr", dump_addr, 5);
      reset = 1'b0;
      step();
      check_eq("rstd_valid", dump_valid, 0);
      check_eq("rstd_done", dump_done, 0);
      check_eq("rstd_addr", dump_addr, 0);
      check_eq("rstd_data", dump_data, 0);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read_addr0 = 3'(i);
         read_addr1 = 3'(7 - i);
         step();
         check_eq("rstd_rd0", read_data0, 0);
         check_eq("rstd_rd1", read_data1, 0);
         check_eq("rstd_no_done", dump_done, 0);
         check_eq("rstd_no_valid", dump_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
